cc_bus_initiator: RTL and testbench

// - Initiator end of the hardware-control-point config bus (wr/rd/addr/addr_fixed, 32b data, 19b addr).
// - Takes host commands (write, or read burst) from the command parser, drives bus writes/reads to

---
 rtl/cc_bus_initiator_pkg.sv | 29 ++
 rtl/cc_bus_initiator_rsp_timer.sv | 36 +++
 rtl/cc_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_cc_bus_initiator.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_bus_initiator_pkg.sv
// Shared definitions for the control-point config bus initiator.
// Holds the bus widths, host command type codes, the FSM state encoding
// and the burst address-advance helper.
package cc_bus_initiator_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  // Host command type codes; every other value is rejected with o_cmd_err.
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RSP_HOLD  = 3'd4
  } state_t;

  // Address of the next burst word: wraps modulo 2^ADDR_W, or stays put
  // when the burst targets the fixed-address space.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic              fixed);
    next_addr = fixed ? addr : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cc_bus_initiator_rsp_timer.sv
// Read-response timer.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_load        restart the count at 1 (asserted the cycle of the read strobe)
//   i_run         advance the count while waiting for a response
//   o_expired     count has reached TIMEOUT_CYCLES
// The count sticks at TIMEOUT_CYCLES so o_expired stays up until reloaded.
module cc_bus_initiator_rsp_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_load) begin
      // Loaded during the strobe cycle so the first wait cycle sees 1.
      count_q <= CW'(1);
    end else if (i_run && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign o_expired = (count_q == LIMIT);

endmodule

// File: rtl/cc_bus_initiator.sv
// Initiator end of the control-point config bus.
// Accepts host commands (single write or read burst), drives one-cycle bus
// write/read strobes, waits for each read response with a timeout, and
// hands responses upstream one at a time.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready           host command handshake
//   iv_cmd_type/addr/addr_fixed/wdata/len   command fields
//   o_wr_cc/o_rd_cc, ov_wdata_cc, ov_addr_cc, o_addr_fixed_cc   bus request side
//   i_wr_cc, iv_rdata_cc, iv_raddr_cc, i_addr_fixed_cc          bus response side
//   o_rsp_valid/i_rsp_ready, ov_rsp_data/addr, o_rsp_timeout    upstream response
//   o_cmd_err                         one-cycle pulse for an unknown command type
//   ov_stray_cnt                      saturating count of unmatched responses
//   ov_dbg_state                      current FSM state
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high; the payload must hold while valid is high and ready is low.
module cc_bus_initiator
  import cc_bus_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STRAY_CNT_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             iv_cmd_type,
  input  logic [ADDR_W-1:0]      iv_cmd_addr,
  input  logic                   i_cmd_addr_fixed,
  input  logic [DATA_W-1:0]      iv_cmd_wdata,
  input  logic [LEN_W-1:0]       iv_cmd_len,
  output logic                   o_wr_cc,
  output logic                   o_rd_cc,
  output logic [DATA_W-1:0]      ov_wdata_cc,
  output logic [ADDR_W-1:0]      ov_addr_cc,
  output logic                   o_addr_fixed_cc,
  input  logic                   i_wr_cc,
  input  logic [DATA_W-1:0]      iv_rdata_cc,
  input  logic [ADDR_W-1:0]      iv_raddr_cc,
  input  logic                   i_addr_fixed_cc,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_W-1:0]      ov_rsp_data,
  output logic [ADDR_W-1:0]      ov_rsp_addr,
  output logic                   o_rsp_timeout,
  output logic                   o_cmd_err,
  output logic [STRAY_CNT_W-1:0] ov_stray_cnt,
  output logic [2:0]             ov_dbg_state
);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q;
  logic                     fixed_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [LEN_W-1:0]         remain_q;
  logic [DATA_W-1:0]        rsp_data_q;
  logic [ADDR_W-1:0]        rsp_addr_q;
  logic                     rsp_timeout_q;
  logic                     cmd_err_q;
  logic [STRAY_CNT_W-1:0]   stray_q;

  logic cmd_fire, is_write, is_read;
  logic in_wait, rsp_match, got_match, timed_out, rsp_accept, more_words;
  logic timer_expired;

  // Ready is forced low while reset is asserted so nothing is accepted in
  // the reset cycle, and comes up in the first cycle after it.
  assign o_cmd_ready = (state_q == ST_IDLE) && !i_rst;
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign is_write    = (iv_cmd_type == CMD_WRITE);
  assign is_read     = (iv_cmd_type == CMD_READ);

  assign in_wait    = (state_q == ST_READ_WAIT);
  assign rsp_match  = i_wr_cc && (iv_raddr_cc == addr_q) && (i_addr_fixed_cc == fixed_q);
  assign got_match  = in_wait && rsp_match;
  // A match in the expiry cycle takes priority over the timeout.
  assign timed_out  = in_wait && timer_expired && !rsp_match;
  assign rsp_accept = (state_q == ST_RSP_HOLD) && i_rsp_ready;
  // A timed-out word aborts whatever is left of the burst.
  assign more_words = (remain_q != '0) && !rsp_timeout_q;

  cc_bus_initiator_rsp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (state_q == ST_READ_REQ),
    .i_run     (in_wait),
    .o_expired (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (is_write)     state_d = ST_WRITE;
          else if (is_read) state_d = ST_READ_REQ;
        end
      end
      ST_WRITE:     state_d = ST_IDLE;
      ST_READ_REQ:  state_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        if (got_match || timed_out) state_d = ST_RSP_HOLD;
      end
      ST_RSP_HOLD: begin
        if (rsp_accept) state_d = more_words ? ST_READ_REQ : ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      fixed_q       <= 1'b0;
      wdata_q       <= '0;
      remain_q      <= '0;
      rsp_data_q    <= '0;
      rsp_addr_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      stray_q       <= '0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= cmd_fire && !is_write && !is_read;

      if (cmd_fire && (is_write || is_read)) begin
        addr_q   <= iv_cmd_addr;
        fixed_q  <= i_cmd_addr_fixed;
        wdata_q  <= iv_cmd_wdata;
        remain_q <= iv_cmd_len;
      end else if (rsp_accept && more_words) begin
        addr_q   <= next_addr(addr_q, fixed_q);
        remain_q <= remain_q - LEN_W'(1);
      end

      if (got_match) begin
        rsp_data_q    <= iv_rdata_cc;
        rsp_addr_q    <= addr_q;
        rsp_timeout_q <= 1'b0;
      end else if (timed_out) begin
        rsp_data_q    <= '0;
        rsp_addr_q    <= addr_q;
        rsp_timeout_q <= 1'b1;
      end

      // Every response strobe not consumed as the pending read's answer
      // is stray, whatever state the FSM is in.
      if (i_wr_cc && !got_match && (stray_q != '1)) begin
        stray_q <= stray_q + STRAY_CNT_W'(1);
      end
    end
  end

  assign o_wr_cc         = (state_q == ST_WRITE);
  assign o_rd_cc         = (state_q == ST_READ_REQ);
  assign ov_wdata_cc     = wdata_q;
  assign ov_addr_cc      = addr_q;
  assign o_addr_fixed_cc = fixed_q;
  assign o_rsp_valid     = (state_q == ST_RSP_HOLD);
  assign ov_rsp_data     = rsp_data_q;
  assign ov_rsp_addr     = rsp_addr_q;
  assign o_rsp_timeout   = rsp_timeout_q;
  assign o_cmd_err       = cmd_err_q;
  assign ov_stray_cnt    = stray_q;
  assign ov_dbg_state    = state_q;

endmodule

// File: tb/tb_cc_bus_initiator.sv
module tb_cc_bus_initiator;

  localparam int TO = 4;
  localparam int SW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    iv_cmd_type;
  logic [18:0]   iv_cmd_addr;
  logic          i_cmd_addr_fixed;
  logic [31:0]   iv_cmd_wdata;
  logic [7:0]    iv_cmd_len;
  logic          o_wr_cc, o_rd_cc;
  logic [31:0]   ov_wdata_cc;
  logic [18:0]   ov_addr_cc;
  logic          o_addr_fixed_cc;
  logic          i_wr_cc;
  logic [31:0]   iv_rdata_cc;
  logic [18:0]   iv_raddr_cc;
  logic          i_addr_fixed_cc;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   ov_rsp_data;
  logic [18:0]   ov_rsp_addr;
  logic          o_rsp_timeout;
  logic          o_cmd_err;
  logic [SW-1:0] ov_stray_cnt;
  logic [2:0]    ov_dbg_state;

  cc_bus_initiator #(.TIMEOUT_CYCLES(TO), .STRAY_CNT_W(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .iv_cmd_type(iv_cmd_type), .iv_cmd_addr(iv_cmd_addr),
    .i_cmd_addr_fixed(i_cmd_addr_fixed), .iv_cmd_wdata(iv_cmd_wdata),
    .iv_cmd_len(iv_cmd_len),
    .o_wr_cc(o_wr_cc), .o_rd_cc(o_rd_cc), .ov_wdata_cc(ov_wdata_cc),
    .ov_addr_cc(ov_addr_cc), .o_addr_fixed_cc(o_addr_fixed_cc),
    .i_wr_cc(i_wr_cc), .iv_rdata_cc(iv_rdata_cc), .iv_raddr_cc(iv_raddr_cc),
    .i_addr_fixed_cc(i_addr_fixed_cc),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .ov_rsp_data(ov_rsp_data), .ov_rsp_addr(ov_rsp_addr),
    .o_rsp_timeout(o_rsp_timeout), .o_cmd_err(o_cmd_err),
    .ov_stray_cnt(ov_stray_cnt), .ov_dbg_state(ov_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {timeout, addr, data} expected per response word.
  logic [51:0] exp_q[$];
  int          exp_stray = 0;

  // Per-word responder plan for the next read burst.
  int dly[8];    // cycles after the read strobe before replying; > TO means no reply
  int stall[8];  // cycles i_rsp_ready stays low before accepting
  bit wrong[8];  // send a mismatching response one cycle after the strobe

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [SW-1:0] stray_model(input int n);
    stray_model = (n >= (1 << SW) - 1) ? {SW{1'b1}} : SW'(n);
  endfunction

  task automatic set_plan(input int d, input int s, input bit w);
    for (int i = 0; i < 8; i++) begin
      dly[i] = d; stall[i] = s; wrong[i] = w;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [1:0] t, input logic [18:0] a, input logic f,
                          input logic [31:0] wd, input logic [7:0] len);
    int waited;
    iv_cmd_type = t; iv_cmd_addr = a; i_cmd_addr_fixed = f;
    iv_cmd_wdata = wd; iv_cmd_len = len; i_cmd_valid = 1'b1;
    waited = 0;
    while (!o_cmd_ready && waited < 50) begin
      tick(); waited++;
    end
    if (!o_cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_ready_timeout: ready=%0b after %0d cycles, required 1", o_cmd_ready, waited);
    end
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic check_stray(input string tag);
    total++;
    if (ov_stray_cnt !== stray_model(exp_stray)) begin
      bad++;
      $display("FAIL %s stray_cnt: got %0h expected %0h", tag, ov_stray_cnt, stray_model(exp_stray));
    end
  endtask

  // Read burst driver + responder + response checker. Expected addresses
  // come straight from the burst rule: base + k mod 2^19, or base if fixed.
  task automatic do_read(input logic [18:0] a, input logic f, input int len, input string tag);
    logic [18:0] wa;
    logic [31:0] d;
    logic [51:0] got;
    bit          to;
    int          rd_extra;
    int          last;
    rd_extra = 0;
    send_cmd(2'b10, a, f, 32'h0, 8'(len));
    for (int k = 0; k <= len; k++) begin
      wa = f ? a : 19'(a + 19'(k));
      total++;
      if (o_rd_cc !== 1'b1 || ov_addr_cc !== wa || o_addr_fixed_cc !== f) begin
        bad++;
        $display("FAIL %s rd_strobe[%0d]: rd=%0b addr=%05h fixed=%0b expected rd=1 addr=%05h fixed=%0b",
                 tag, k, o_rd_cc, ov_addr_cc, o_addr_fixed_cc, wa, f);
      end
      to   = (dly[k] > TO);
      d    = $urandom;
      last = to ? TO : dly[k];
      for (int c = 1; c <= last; c++) begin
        tick();
        i_wr_cc = 1'b0;
        if (o_rd_cc) rd_extra++;
        if (!to && c == dly[k]) begin
          i_wr_cc = 1'b1; iv_rdata_cc = d; iv_raddr_cc = wa; i_addr_fixed_cc = f;
        end else if (wrong[k] && c == 1) begin
          i_wr_cc = 1'b1; iv_rdata_cc = ~d; iv_raddr_cc = wa ^ 19'h1; i_addr_fixed_cc = f;
          exp_stray++;
        end
      end
      exp_q.push_back(to ? {1'b1, wa, 32'h0} : {1'b0, wa, d});
      tick();
      i_wr_cc = 1'b0;
      for (int s = 0; s <= stall[k]; s++) begin
        got = {o_rsp_timeout, ov_rsp_addr, ov_rsp_data};
        total++;
        if (o_rsp_valid !== 1'b1 || got !== exp_q[0]) begin
          bad++;
          $display("FAIL %s rsp[%0d] cyc%0d: valid=%0b got %013h expected valid=1 %013h",
                   tag, k, s, o_rsp_valid, got, exp_q[0]);
        end
        if (s == stall[k]) i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
      end
      void'(exp_q.pop_front());
      if (to || k == len) begin
        total++;
        if (o_cmd_ready !== 1'b1 || o_rd_cc !== 1'b0 || rd_extra != 0) begin
          bad++;
          $display("FAIL %s end_idle: ready=%0b rd=%0b extra_rd=%0d expected ready=1 rd=0 extra_rd=0",
                   tag, o_cmd_ready, o_rd_cc, rd_extra);
        end
        break;
      end
    end
    check_stray(tag);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1; i_cmd_valid = 1'b0; iv_cmd_type = 2'b00; iv_cmd_addr = '0;
    i_cmd_addr_fixed = 1'b0; iv_cmd_wdata = '0; iv_cmd_len = '0; i_wr_cc = 1'b0;
    iv_rdata_cc = '0; iv_raddr_cc = '0; i_addr_fixed_cc = 1'b0; i_rsp_ready = 1'b0;
    tick(); tick();
    total++;
    if ({o_cmd_ready, o_wr_cc, o_rd_cc, o_rsp_valid, o_cmd_err, o_rsp_timeout} !== 6'b0 ||
        ov_stray_cnt !== '0 || ov_rsp_data !== '0 || ov_addr_cc !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%0b wr=%0b rd=%0b rsp_v=%0b err=%0b stray=%0h expected all 0",
               o_cmd_ready, o_wr_cc, o_rd_cc, o_rsp_valid, o_cmd_err, ov_stray_cnt);
    end
    i_rst = 1'b0;
    #1;
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after: got %0b expected 1", o_cmd_ready);
    end
    exp_stray = 0;
  endtask

  task automatic test_write(input logic [18:0] a, input logic [31:0] wd, input logic f);
    send_cmd(2'b01, a, f, wd, 8'h0);
    total++;
    if (o_wr_cc !== 1'b1 || o_rd_cc !== 1'b0 || ov_wdata_cc !== wd || ov_addr_cc !== a ||
        o_addr_fixed_cc !== f || o_cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL write_strobe: wr=%0b rd=%0b data=%08h addr=%05h fixed=%0b ready=%0b expected wr=1 rd=0 data=%08h addr=%05h fixed=%0b ready=0",
               o_wr_cc, o_rd_cc, ov_wdata_cc, ov_addr_cc, o_addr_fixed_cc, o_cmd_ready, wd, a, f);
    end
    tick();
    total++;
    if (o_wr_cc !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_after: wr=%0b ready=%0b expected wr=0 ready=1", o_wr_cc, o_cmd_ready);
    end
  endtask

  task automatic test_cmd_err(input logic [1:0] t);
    send_cmd(t, 19'h00123, 1'b0, 32'h1234_5678, 8'h2);
    total++;
    if (o_cmd_err !== 1'b1 || o_wr_cc !== 1'b0 || o_rd_cc !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_err_pulse type=%0b: err=%0b wr=%0b rd=%0b ready=%0b expected err=1 wr=0 rd=0 ready=1",
               t, o_cmd_err, o_wr_cc, o_rd_cc, o_cmd_ready);
    end
    tick();
    total++;
    if (o_cmd_err !== 1'b0 || o_wr_cc !== 1'b0 || o_rd_cc !== 1'b0) begin
      bad++;
      $display("FAIL cmd_err_clear type=%0b: err=%0b wr=%0b rd=%0b expected 0 0 0", t, o_cmd_err, o_wr_cc, o_rd_cc);
    end
  endtask

  task automatic test_read_wrap();
    set_plan(3, 0, 1'b0);
    do_read(19'h7FFFE, 1'b0, 2, "read_wrap");
  endtask

  task automatic test_read_fixed_stall();
    set_plan(2, 5, 1'b0);
    do_read(19'h00010, 1'b1, 1, "read_fixed_stall");
  endtask

  task automatic test_timeout();
    set_plan(99, 0, 1'b0);
    do_read(19'h00200, 1'b0, 3, "timeout");
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (o_rd_cc !== 1'b0 || o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL timeout_quiet cyc%0d: rd=%0b rsp_v=%0b ready=%0b expected 0 0 1",
                 i, o_rd_cc, o_rsp_valid, o_cmd_ready);
      end
    end
  endtask

  task automatic test_match_at_expiry();
    set_plan(TO, 1, 1'b0);
    do_read(19'h01000, 1'b0, 1, "match_at_expiry");
  endtask

  task automatic test_wrong_addr();
    set_plan(3, 0, 1'b1);
    do_read(19'h00ABC, 1'b0, 0, "wrong_addr");
  endtask

  task automatic test_idle_stray();
    i_wr_cc = 1'b1; iv_raddr_cc = 19'h00ABC; i_addr_fixed_cc = 1'b0;
    tick();
    i_wr_cc = 1'b0;
    exp_stray++;
    check_stray("idle_stray");
  endtask

  task automatic test_random();
    int r, len;
    logic [18:0] a;
    logic [31:0] wd;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? 19'(19'h7FFFF - 19'($urandom_range(0, 3))) : 19'($urandom);
      if (r < 3) begin
        wd = $urandom;
        test_write(a, wd, 1'($urandom_range(0, 1)));
      end else if (r < 4) begin
        test_cmd_err(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
      end else begin
        len = $urandom_range(0, 4);
        for (int i = 0; i < 8; i++) begin
          dly[i]   = ($urandom_range(1, 12) > 10) ? 99 : $urandom_range(1, TO);
          stall[i] = $urandom_range(0, 3);
          wrong[i] = ($urandom_range(0, 3) == 0);
        end
        do_read(a, 1'($urandom_range(0, 1)), len, "random_read");
      end
    end
  endtask

  task automatic test_stray_saturate();
    i_wr_cc = 1'b1; iv_raddr_cc = 19'h0; i_addr_fixed_cc = 1'b0;
    for (int i = 0; i < (1 << SW) + 4; i++) begin
      tick();
      exp_stray++;
    end
    check_stray("stray_saturate");
    tick();
    exp_stray++;
    i_wr_cc = 1'b0;
    tick();
    total++;
    if (ov_stray_cnt !== {SW{1'b1}}) begin
      bad++;
      $display("FAIL stray_hold: got %0h expected %0h", ov_stray_cnt, {SW{1'b1}});
    end
  endtask

  task automatic test_reset_mid_read();
    send_cmd(2'b10, 19'h00300, 1'b0, 32'h0, 8'h3);
    tick();
    total++;
    if (o_rd_cc !== 1'b0 || o_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_wait: rd=%0b rsp_v=%0b expected 0 0", o_rd_cc, o_rsp_valid);
    end
    i_rst = 1'b1;
    tick();
    total++;
    if (o_cmd_ready !== 1'b0 || o_rsp_valid !== 1'b0 || o_rd_cc !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_read: ready=%0b rsp_v=%0b rd=%0b expected 0 0 0",
               o_cmd_ready, o_rsp_valid, o_rd_cc);
    end
    i_rst = 1'b0;
    exp_stray = 0;
    #1;
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_mid_reset: got %0b expected 1", o_cmd_ready);
    end
    check_stray("stray_after_reset");
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (o_rsp_valid !== 1'b0 || o_rd_cc !== 1'b0) begin
        bad++;
        $display("FAIL no_rsp_after_reset cyc%0d: rsp_v=%0b rd=%0b expected 0 0", i, o_rsp_valid, o_rd_cc);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write(19'h12345, 32'hDEADBEEF, 1'b0);
    test_wrong_addr();
    test_read_wrap();
    test_read_fixed_stall();
    test_timeout();
    test_match_at_expiry();
    test_cmd_err(2'b11);
    test_cmd_err(2'b00);
    test_idle_stray();
    test_random();
    test_stray_saturate();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
